spart_rx_fifo: RTL and testbench

Receive-side buffer between the SPART receiver and the driver.
- Captures each completed byte when the SPART raises rda.
- Holds bytes in a first-word-fall-through FIFO so the driver can drain them at its own pace without losing characters.
- Reports occupancy, an almost-full watermark, and a sticky overrun flag when a byte arrives with no free slot.

---
 rtl/spart_rx_fifo.sv | 118 +++++++++++
 tb/tb_spart_rx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx_fifo.sv
// rtl/spart_rx_fifo.sv - SPART receive byte FIFO (first-word fall-through)
//
// Purpose: captures one byte per rising edge of the SPART rda level and
// buffers it until the driver pops it. Reports occupancy, an almost-full
// watermark and a sticky overrun flag for bytes dropped while full.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rda_in        - SPART receive-data-available level (rising edge = new byte)
//   rx_data       - SPART receive byte, sampled in the push cycle
//   rd_en         - pop request, ignored while empty
//   clr_ovr       - single-cycle clear for the overrun flag
//   rd_data       - head byte, 0 when empty
//   empty, full, almost_full, count - occupancy status
//   overrun       - sticky: a byte arrived with no free slot
module spart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 8,
    parameter int AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rda_in,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rd_en,
    input  logic                     clr_ovr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rda_d_q, rda_d_d;
    logic          overrun_q, overrun_d;

    logic push;
    logic pop;
    logic wr_en;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign rd_data     = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        push  = rda_in & ~rda_d_q;
        pop   = rd_en & ~empty;
        // When full, a simultaneous pop frees the slot the new byte lands in.
        wr_en = push & (~full | pop);

        rda_d_d   = rda_in;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear so a drop in the clear cycle is not lost.
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (push && full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            // Track rda_in through reset so a level already high when reset
            // releases is not mistaken for a fresh byte.
            rda_d_q   <= rda_in;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rda_d_q   <= rda_d_d;
        end
    end

    // Storage is not reset; only the pointers define which slots are valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_spart_rx_fifo.sv
// tb/tb_spart_rx_fifo.sv - randomized self-checking bench for spart_rx_fifo
module tb_spart_rx_fifo;

    localparam int DEPTH    = 16;
    localparam int DATA_W   = 8;
    localparam int AF_LEVEL = 12;

    logic              clk;
    logic              rst;
    logic              rda_in;
    logic [DATA_W-1:0] rx_data;
    logic              rd_en;
    logic              clr_ovr;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [$clog2(DEPTH):0] count;
    logic              overrun;

    spart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rst(rst), .rda_in(rda_in), .rx_data(rx_data),
        .rd_en(rd_en), .clr_ovr(clr_ovr), .rd_data(rd_data),
        .empty(empty), .full(full), .almost_full(almost_full),
        .count(count), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a byte queue, the last seen rda level and the overrun bit.
    logic [DATA_W-1:0] q[$];
    logic              m_prev_rda = 1'b0;
    logic              m_ovr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model with the inputs currently driven.
    task automatic model_edge();
        logic rise;
        if (rst) begin
            q.delete();
            m_ovr = 1'b0;
            m_prev_rda = rda_in;
        end else begin
            rise = rda_in && !m_prev_rda;
            m_prev_rda = rda_in;
            if (clr_ovr) m_ovr = 1'b0;
            if (rd_en && q.size() > 0) void'(q.pop_front());
            if (rise) begin
                if (q.size() < DEPTH) q.push_back(rx_data);
                else m_ovr = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check_eq({tag, ".count"}, 32'(count), 32'(n));
        check_eq({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check_eq({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check_eq({tag, ".afull"}, 32'(almost_full), 32'(n >= AF_LEVEL));
        check_eq({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        check_eq({tag, ".rd_data"}, 32'(rd_data), (n == 0) ? 32'd0 : 32'(q[0]));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic push_byte(input logic [7:0] b, input string tag);
        rda_in = 1'b1; rx_data = b;
        cycle(tag);
        rda_in = 1'b0; rx_data = 8'($urandom);
        cycle(tag);
    endtask

    task automatic pop_one(input string tag);
        rd_en = 1'b1;
        cycle(tag);
        rd_en = 1'b0;
    endtask

    logic [7:0] hello [10] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};

    initial begin
        rst = 1'b1; rda_in = 1'b0; rx_data = '0; rd_en = 1'b0; clr_ovr = 1'b0;
        cycle("reset");
        cycle("reset");
        rst = 1'b0;
        cycle("idle");

        // 1: single byte then pop
        push_byte(8'h48, "t1_push");
        check_eq("t1_head", 32'(rd_data), 32'h48);
        pop_one("t1_pop");
        check_eq("t1_empty", 32'(empty), 32'd1);

        // 2: HELLOWORLD burst then drain with rd_en held
        foreach (hello[i]) push_byte(hello[i], "t2_push");
        check_eq("t2_count10", 32'(count), 32'd10);
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("t2_order", 32'(rd_data), 32'(hello[i]));
            cycle("t2_drain");
        end
        rd_en = 1'b0;
        check_eq("t2_empty", 32'(empty), 32'd1);

        // 3: fill to almost_full, full, overrun, drain, clear
        for (int i = 0; i < 12; i++) push_byte(8'($urandom_range(0, 8'h7F)), "t3_fill");
        check_eq("t3_afull", 32'(almost_full), 32'd1);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 8'h7F)), "t3_fill");
        check_eq("t3_full", 32'(full), 32'd1);
        push_byte(8'hAA, "t3_drop");
        check_eq("t3_ovr", 32'(overrun), 32'd1);
        check_eq("t3_cnt16", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("t3_noAA", 32'(rd_data == 8'hAA), 32'd0);
            pop_one("t3_drain");
        end
        clr_ovr = 1'b1;
        cycle("t3_clr");
        clr_ovr = 1'b0;
        check_eq("t3_ovr_clr", 32'(overrun), 32'd0);

        // 4: push+pop while full, then 40 wrapping push/pop pairs
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), "t4_fill");
        rda_in = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
        cycle("t4_both");
        rda_in = 1'b0; rd_en = 1'b0;
        cycle("t4_both");
        check_eq("t4_cnt16", 32'(count), 32'd16);
        check_eq("t4_noovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 40; i++) begin
            rda_in = 1'b1; rx_data = 8'($urandom); rd_en = 1'b1;
            cycle("t4_wrap");
            rda_in = 1'b0; rd_en = 1'b0;
            cycle("t4_wrap");
        end
        for (int i = 0; i < DEPTH; i++) pop_one("t4_drain");

        // 5: held rda, pop while empty, push+pop while empty
        rda_in = 1'b1; rx_data = 8'h31;
        for (int i = 0; i < 20; i++) cycle("t5_hold");
        rda_in = 1'b0;
        check_eq("t5_one", 32'(count), 32'd1);
        pop_one("t5_pop");
        rd_en = 1'b1;
        cycle("t5_empty_rd");
        cycle("t5_empty_rd");
        rda_in = 1'b1; rx_data = 8'h77;
        cycle("t5_both");
        rda_in = 1'b0; rd_en = 1'b0;
        check_eq("t5_cnt1", 32'(count), 32'd1);
        pop_one("t5_drain");

        // 6: reset with data stored and rda held high
        for (int i = 0; i < 7; i++) push_byte(8'($urandom), "t6_fill");
        rda_in = 1'b1; rx_data = 8'h99; rst = 1'b1;
        cycle("t6_rst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle("t6_hold");
        check_eq("t6_nopush", 32'(count), 32'd0);
        rda_in = 1'b0;
        cycle("t6_low");
        rda_in = 1'b1;
        cycle("t6_rise");
        check_eq("t6_push", 32'(count), 32'd1);
        rda_in = 1'b0;
        cycle("t6_low");

        // Random traffic, including occasional resets
        for (int i = 0; i < 2000; i++) begin
            rda_in  = ($urandom_range(0, 2) != 0) ? ~rda_in : rda_in;
            rx_data = 8'($urandom);
            rd_en   = ($urandom_range(0, 3) == 0);
            clr_ovr = ($urandom_range(0, 30) == 0);
            rst     = ($urandom_range(0, 300) == 0);
            cycle("rand");
        end
        rst = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0; rda_in = 1'b0;
        cycle("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
